// File: rtl/debounce_sync_if.sv
// debounce_sync_if: raw input, sample tick and conditioned outputs of the debouncer
interface debounce_sync_if;
  logic en;
  logic din;
  logic q;
  logic q_bar;
  logic rise;
  logic fall;
  logic busy;
  modport master(output en, din, input q, q_bar, rise, fall, busy);
  modport slave(input en, din, output q, q_bar, rise, fall, busy);
endinterface

// File: rtl/debounce_sync.sv
// debounce_sync: metastability synchronizer followed by a counter-based debounce FSM
module debounce_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  debounce_sync_if.slave bus
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  // bit 1 is the accepted level, bit 0 marks a pending change
  localparam logic [1:0] STABLE_LOW = 2'b00;
  localparam logic [1:0] WAIT_HIGH = 2'b01;
  localparam logic [1:0] STABLE_HIGH = 2'b10;
  localparam logic [1:0] WAIT_LOW = 2'b11;
  logic [SYNC_STAGES-1:0] sync;
  logic [1:0] state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic accept, rise_r, fall_r, s;
  assign s = sync[SYNC_STAGES-1];
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    accept = 1'b0;
    if (bus.en) begin
      if (state == STABLE_LOW || state == STABLE_HIGH) begin
        if (s != state[1]) begin
          state_n = state[1] ? WAIT_LOW : WAIT_HIGH;
          cnt_n = CNT_W'(1);
        end
      end else if (s == state[1]) begin
        state_n = state[1] ? STABLE_HIGH : STABLE_LOW;
        cnt_n = '0;
      end else if (cnt == CNT_MAX) begin
        state_n = state[1] ? STABLE_LOW : STABLE_HIGH;
        cnt_n = '0;
        accept = 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      state <= STABLE_LOW;
      cnt <= '0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.din};
      state <= state_n;
      cnt <= cnt_n;
      rise_r <= accept & ~state[1];
      fall_r <= accept & state[1];
    end
  end
  assign bus.q = state[1];
  assign bus.q_bar = ~state[1];
  assign bus.busy = state[0];
  assign bus.rise = rise_r;
  assign bus.fall = fall_r;
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: directed and random checks of two debouncer configurations against a run-length model
module tb_debounce_sync;
  localparam int S0 = 2, D0 = 4, S1 = 3, D1 = 2;
  logic clk = 1'b0, reset = 1'b0, din = 1'b0, en = 1'b0;
  int total = 0, bad = 0, edge_n = 0, nr = 0;
  int dc[2] = '{D0, D1};
  logic mq[2], mrise[2], mfall[2];
  int run[2];
  logic mh0[$], mh1[$];
  debounce_sync_if b0();
  debounce_sync_if b1();
  assign b0.din = din;
  assign b0.en = en;
  assign b1.din = din;
  assign b1.en = en;
  debounce_sync #(.SYNC_STAGES(S0), .DEBOUNCE_CYCLES(D0)) u0(.clk(clk), .reset(reset), .bus(b0));
  debounce_sync #(.SYNC_STAGES(S1), .DEBOUNCE_CYCLES(D1)) u1(.clk(clk), .reset(reset), .bus(b1));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic got, logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d got=%b exp=%b", tag, edge_n, got, exp);
    end
  endtask
  task automatic model_reset();
    mh0 = {};
    mh1 = {};
    for (int i = 0; i < S0; i++) mh0.push_back(1'b0);
    for (int i = 0; i < S1; i++) mh1.push_back(1'b0);
    for (int d = 0; d < 2; d++) begin
      mq[d] = 1'b0;
      run[d] = 0;
      mrise[d] = 1'b0;
      mfall[d] = 1'b0;
    end
  endtask
  // q flips once DEBOUNCE_CYCLES consecutive enabled samples disagree with it
  task automatic model_edge(int d, logic s);
    mrise[d] = 1'b0;
    mfall[d] = 1'b0;
    if (en) begin
      if (s != mq[d]) begin
        run[d]++;
        if (run[d] == dc[d]) begin
          mq[d] = ~mq[d];
          run[d] = 0;
          mrise[d] = mq[d];
          mfall[d] = ~mq[d];
        end
      end else run[d] = 0;
    end
  endtask
  task automatic check_all();
    chk("q0", b0.q, mq[0]);
    chk("qbar0", b0.q_bar, ~mq[0]);
    chk("rise0", b0.rise, mrise[0]);
    chk("fall0", b0.fall, mfall[0]);
    chk("busy0", b0.busy, run[0] > 0);
    chk("q1", b1.q, mq[1]);
    chk("qbar1", b1.q_bar, ~mq[1]);
    chk("rise1", b1.rise, mrise[1]);
    chk("fall1", b1.fall, mfall[1]);
    chk("busy1", b1.busy, run[1] > 0);
  endtask
  task automatic step(logic d_in, logic e);
    logic s0, s1;
    din = d_in;
    en = e;
    @(posedge clk);
    edge_n++;
    s0 = mh0.pop_front();
    mh0.push_back(din);
    s1 = mh1.pop_front();
    mh1.push_back(din);
    model_edge(0, s0);
    model_edge(1, s1);
    #1;
    check_all();
  endtask
  task automatic do_reset();
    reset = 1'b0;
    din = 1'b0;
    en = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
    edge_n = 0;
  endtask
  initial begin
    model_reset();
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 1'b1);
      if (i >= 3 && i <= 5) chk("clean_rise_busy", b0.busy, 1'b1);
      if (i == 5) chk("clean_rise_q_early", b0.q, 1'b0);
      if (i == 6) chk("clean_rise_q", b0.q, 1'b1);
      if (i == 6) chk("clean_rise_pulse", b0.rise, 1'b1);
      if (i == 7) chk("clean_rise_drop", b0.rise, 1'b0);
      if (i == 4) chk("bound_q_early", b1.q, 1'b0);
      if (i == 5) chk("bound_q", b1.q, 1'b1);
      if (i == 5) chk("bound_rise", b1.rise, 1'b1);
    end
    edge_n = 0;
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 1'b1);
      if (i == 5) chk("clean_fall_q_early", b0.q, 1'b1);
      if (i == 6) chk("clean_fall_q", b0.q, 1'b0);
      if (i == 6) chk("clean_fall_qbar", b0.q_bar, 1'b1);
      if (i == 6) chk("clean_fall_pulse", b0.fall, 1'b1);
      if (i == 7) chk("clean_fall_drop", b0.fall, 1'b0);
    end
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(i <= 3, 1'b1);
      chk("glitch_q", b0.q, 1'b0);
      chk("glitch_rise", b0.rise, 1'b0);
    end
    chk("glitch_idle", b0.busy, 1'b0);
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      step(i == 1, 1'b1);
      chk("bounce1_q", b1.q, 1'b0);
      chk("bounce1_rise", b1.rise, 1'b0);
    end
    chk("bounce1_idle", b1.busy, 1'b0);
    do_reset();
    nr = 0;
    for (int i = 1; i <= 14; i++) begin
      step(1'b1, !(i >= 5 && i <= 9));
      nr += int'(b0.rise);
      if (i >= 5 && i <= 9) chk("gate_no_pulse", b0.rise, 1'b0);
      if (i == 10) chk("gate_q_early", b0.q, 1'b0);
      if (i == 11) chk("gate_q", b0.q, 1'b1);
    end
    total++;
    assert (nr == 1) else begin
      bad++;
      $error("FAIL gate_rise_count got=%0d exp=1", nr);
    end
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1);
    chk("pre_reset_busy", b0.busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("areset_q", b0.q, 1'b0);
    chk("areset_qbar", b0.q_bar, 1'b1);
    chk("areset_busy", b0.busy, 1'b0);
    chk("areset_rise", b0.rise, 1'b0);
    check_all();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("held_q", b0.q, 1'b0);
      chk("held_busy", b0.busy, 1'b0);
      chk("held_rise1", b1.rise, 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) din = ~din;
      step(din, $urandom_range(3) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
